ixc_gfifo_arb: RTL and testbench

Round-robin scheduler that shares the single global-FIFO write channel (GFtsReq/GFcbid/GFlen/GFidata, backpressured by GFfull) among NPORT gfifo ports. Each port presents a packet (callback id, beat count, 512-bit data beats out of its local loopback buffer). The arbiter grants one port at a time, emits one header strobe and then streams the packet's data beats. It sits between the per-port gfifo logic and the GFIFO, under xc_top's global GFLock.

---
 rtl/ixc_gfifo_arb.sv | 135 +++++++++++++
 tb/tb_ixc_gfifo_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_gfifo_arb.sv
// Round-robin scheduler sharing the single GFIFO write channel among NPORT ports.
// Each grant emits one header strobe, then streams len data beats from the granted port.
module ixc_gfifo_arb #(
   parameter int NPORT = 4,
   parameter int DW    = 512,
   parameter int CW    = 20,
   parameter int LW    = 12
) (
   input  logic                fclk,
   input  logic                rst,
   input  logic                GFLock,
   input  logic [NPORT-1:0]    req,
   input  logic [NPORT*CW-1:0] cbid,
   input  logic [NPORT*LW-1:0] len,
   input  logic [NPORT*DW-1:0] idata,
   input  logic                GFfull,
   output logic [NPORT-1:0]    gnt,
   output logic [NPORT-1:0]    pop,
   output logic [NPORT-1:0]    done,
   output logic                GFtsReq,
   output logic                GFwr,
   output logic [CW-1:0]       GFcbid,
   output logic [LW-1:0]       GFlen,
   output logic [DW-1:0]       GFidata,
   output logic                busy
);
   localparam int PW = $clog2(NPORT);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t            state_q;
   logic [PW-1:0]     rr_ptr_q;
   logic [PW-1:0]     gidx_q;
   logic [LW-1:0]     cnt_q;
   logic [NPORT-1:0]  gnt_q;
   logic [CW-1:0]     cbid_q;
   logic [LW-1:0]     len_q;

   logic [CW-1:0]     cbid_a  [NPORT];
   logic [LW-1:0]     len_a   [NPORT];
   logic [DW-1:0]     idata_a [NPORT];

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
      assign cbid_a[gi]  = cbid[gi*CW +: CW];
      assign len_a[gi]   = len[gi*LW +: LW];
      assign idata_a[gi] = idata[gi*DW +: DW];
   end

   // First requester at or after rr_ptr, wrapping modulo NPORT.
   logic          sel_found;
   logic [PW-1:0] sel_idx;
   logic [PW:0]   arb_sum;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      arb_sum   = '0;
      for (int k = 0; k < NPORT; k++) begin
         arb_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (arb_sum >= (PW+1)'(NPORT))
            arb_sum = arb_sum - (PW+1)'(NPORT);
         if (!sel_found && req[arb_sum[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = arb_sum[PW-1:0];
         end
      end
   end

   logic          hdr_acc;
   logic          dat_acc;
   logic          last_xfer;
   logic [PW-1:0] rr_next;

   assign hdr_acc   = (state_q == HDR)  && !GFfull;
   assign dat_acc   = (state_q == DATA) && !GFfull;
   assign last_xfer = (hdr_acc && (cnt_q == '0)) || (dat_acc && (cnt_q == LW'(1)));
   assign rr_next   = (gidx_q == PW'(NPORT-1)) ? '0 : gidx_q + 1'b1;

   assign GFtsReq = hdr_acc;
   assign GFwr    = dat_acc;
   assign pop     = dat_acc   ? gnt_q : '0;
   assign done    = last_xfer ? gnt_q : '0;
   assign GFidata = dat_acc   ? idata_a[gidx_q] : '0;
   assign gnt     = gnt_q;
   assign GFcbid  = cbid_q;
   assign GFlen   = len_q;
   assign busy    = (state_q != IDLE);

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
         cnt_q    <= '0;
         gnt_q    <= '0;
         cbid_q   <= '0;
         len_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!GFLock && sel_found) begin
                  gnt_q   <= {{(NPORT-1){1'b0}}, 1'b1} << sel_idx;
                  gidx_q  <= sel_idx;
                  cbid_q  <= cbid_a[sel_idx];
                  len_q   <= len_a[sel_idx];
                  cnt_q   <= len_a[sel_idx];
                  state_q <= HDR;
               end
            end
            HDR: begin
               if (hdr_acc) begin
                  if (cnt_q == '0) begin
                     gnt_q    <= '0;
                     rr_ptr_q <= rr_next;
                     state_q  <= IDLE;
                  end else begin
                     state_q  <= DATA;
                  end
               end
            end
            DATA: begin
               if (dat_acc) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == LW'(1)) begin
                     gnt_q    <= '0;
                     rr_ptr_q <= rr_next;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ixc_gfifo_arb.sv
// Directed bench for ixc_gfifo_arb: a per-cycle vector table followed by
// hand-written multi-cycle sequences (round robin, backpressure, lock, reset).
module tb_ixc_gfifo_arb;
   localparam int NPORT = 4;
   localparam int DW    = 512;
   localparam int CW    = 20;
   localparam int LW    = 12;

   logic                fclk = 1'b0;
   logic                rst;
   logic                GFLock;
   logic [NPORT-1:0]    req;
   logic [NPORT*CW-1:0] cbid;
   logic [NPORT*LW-1:0] len;
   logic [NPORT*DW-1:0] idata;
   logic                GFfull;
   logic [NPORT-1:0]    gnt, pop, done;
   logic                GFtsReq, GFwr, busy;
   logic [CW-1:0]       GFcbid;
   logic [LW-1:0]       GFlen;
   logic [DW-1:0]       GFidata;

   always #5 fclk = ~fclk;

   ixc_gfifo_arb #(.NPORT(NPORT), .DW(DW), .CW(CW), .LW(LW)) dut (
      .fclk(fclk), .rst(rst), .GFLock(GFLock), .req(req), .cbid(cbid), .len(len),
      .idata(idata), .GFfull(GFfull), .gnt(gnt), .pop(pop), .done(done),
      .GFtsReq(GFtsReq), .GFwr(GFwr), .GFcbid(GFcbid), .GFlen(GFlen),
      .GFidata(GFidata), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Port buffer model: beat index advances on each pop.
   int beat [NPORT];

   function automatic logic [DW-1:0] pat(input int p, input int b);
      return {16{8'(p), 24'(b)}};
   endfunction

   always_comb begin
      idata = '0;
      for (int p = 0; p < NPORT; p++) idata[p*DW +: DW] = pat(p, beat[p]);
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [NPORT-1:0] v);
      for (int p = 0; p < NPORT; p++) if (v[p]) return p;
      return -1;
   endfunction

   task automatic set_port(input int p, input logic [CW-1:0] c, input logic [LW-1:0] l);
      cbid[p*CW +: CW] = c;
      len[p*LW +: LW]  = l;
   endtask

   // Per-cycle monitor with port behaviour (drop req on done, advance beat on pop).
   int cyc_n;
   int hdr_port[$];
   int hdr_cyc[$];
   logic [CW-1:0] hdr_cbid[$];
   logic [DW-1:0] wdata[$];
   int wr_n, pop_n, full_viol;
   int done_n [NPORT];
   int pop_p  [NPORT];

   task automatic clr_log();
      hdr_port.delete(); hdr_cyc.delete(); hdr_cbid.delete(); wdata.delete();
      wr_n = 0; pop_n = 0; full_viol = 0; cyc_n = 0;
      for (int p = 0; p < NPORT; p++) begin done_n[p] = 0; pop_p[p] = 0; end
   endtask

   task automatic cyc();
      #1;
      if (GFtsReq) begin
         hdr_port.push_back(oh2i(gnt)); hdr_cyc.push_back(cyc_n); hdr_cbid.push_back(GFcbid);
      end
      if (GFwr) begin wr_n++; wdata.push_back(GFidata); end
      if (GFfull && (GFtsReq || GFwr || (pop != '0))) full_viol++;
      for (int p = 0; p < NPORT; p++) begin
         if (pop[p])  begin pop_n++; pop_p[p]++; beat[p]++; end
         if (done[p]) begin done_n[p]++; req[p] = 1'b0; end
      end
      @(posedge fclk); #2;
      cyc_n++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge fclk); #2;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [NPORT-1:0] req;
      logic             full;
      logic             lock;
      logic [NPORT-1:0] e_gnt, e_pop, e_done;
      logic             e_ts, e_wr, e_busy;
      logic [CW-1:0]    e_cbid;
      logic [LW-1:0]    e_len;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   task automatic setv(input int i, input logic [3:0] r, input logic f, input logic l,
                       input logic [3:0] g, input logic [3:0] pp, input logic [3:0] d,
                       input logic ts, input logic wr, input logic b,
                       input logic [CW-1:0] c, input logic [LW-1:0] ln);
      tbl[i] = '{req:r, full:f, lock:l, e_gnt:g, e_pop:pp, e_done:d,
                 e_ts:ts, e_wr:wr, e_busy:b, e_cbid:c, e_len:ln};
   endtask

   int base;
   bit rer;

   initial begin
      // Port 0: cbid 0x12345 len 3; port 2: header-only packet.
      setv(0,  4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 20'h0,     12'd0);
      setv(1,  4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1, 20'h12345, 12'd3);
      setv(2,  4'b0001, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 1, 20'h12345, 12'd3);
      setv(3,  4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1, 20'h12345, 12'd3);
      setv(4,  4'b0001, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 1, 20'h12345, 12'd3);
      setv(5,  4'b0001, 0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 20'h12345, 12'd3);
      setv(6,  4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 20'h12345, 12'd3);
      setv(7,  4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 20'h12345, 12'd3);
      setv(8,  4'b0100, 0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 0, 1, 20'h00ABC, 12'd0);
      setv(9,  4'b0001, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 20'h00ABC, 12'd0);
      setv(10, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 20'h00ABC, 12'd0);

      for (int p = 0; p < NPORT; p++) beat[p] = 0;
      req = '0; GFLock = 1'b0; GFfull = 1'b0; cbid = '0; len = '0;
      clr_log();
      rst = 1'b1;
      #2;
      chk("reset_state", DW'({gnt, pop, done, GFtsReq, GFwr, busy, GFcbid, GFlen}), '0);
      chk("reset_idata", GFidata, '0);
      @(posedge fclk); #2;
      rst = 1'b0;
      @(posedge fclk); #2;

      set_port(0, 20'h12345, 12'd3);
      set_port(2, 20'h00ABC, 12'd0);
      for (int i = 0; i < NV; i++) begin
         req = tbl[i].req; GFfull = tbl[i].full; GFLock = tbl[i].lock;
         #1;
         chk($sformatf("vec%0d", i),
             DW'({gnt, pop, done, GFtsReq, GFwr, busy, GFcbid, GFlen}),
             DW'({tbl[i].e_gnt, tbl[i].e_pop, tbl[i].e_done, tbl[i].e_ts,
                  tbl[i].e_wr, tbl[i].e_busy, tbl[i].e_cbid, tbl[i].e_len}));
         @(posedge fclk); #2;
      end
      req = '0; GFfull = 1'b0; GFLock = 1'b0;

      // Round robin from rr_ptr=0, all ports len=1, port 0 re-requests.
      do_reset();
      for (int p = 0; p < NPORT; p++) set_port(p, CW'(20'h10 + p), 12'd1);
      clr_log();
      rer = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (done_n[0] == 1 && !rer) begin req[0] = 1'b1; rer = 1'b1; end
      end
      chk("rr_hdr_count", DW'(hdr_port.size()), DW'(5));
      for (int i = 0; i < 5 && i < hdr_port.size(); i++) begin
         chk($sformatf("rr_port%0d", i), DW'(hdr_port[i]), DW'(i % 4));
         chk($sformatf("rr_cyc%0d", i), DW'(hdr_cyc[i]), DW'(1 + 3*i));
      end
      chk("rr_wr_count", DW'(wr_n), DW'(5));

      // GFfull for 5 cycles in the middle of a len=4 packet on port 1.
      set_port(1, 20'h55555, 12'd4);
      clr_log();
      base = beat[1];
      req = 4'b0010;
      for (int k = 0; k < 14; k++) begin
         if (k == 3) GFfull = 1'b1;
         if (k == 8) GFfull = 1'b0;
         cyc();
      end
      chk("full_wr_count", DW'(wr_n), DW'(4));
      chk("full_pop_count", DW'(pop_p[1]), DW'(4));
      chk("full_strobe_while_full", DW'(full_viol), DW'(0));
      chk("full_done", DW'(done_n[1]), DW'(1));
      for (int i = 0; i < 4 && i < wdata.size(); i++)
         chk($sformatf("full_data%0d", i), wdata[i], pat(1, base + i));

      // GFLock raised during port 1 DATA while port 3 waits.
      set_port(3, 20'h33333, 12'd1);
      clr_log();
      req = 4'b0010;
      for (int k = 0; k < 14; k++) begin
         if (k == 2) begin req[3] = 1'b1; GFLock = 1'b1; end
         if (k == 9) GFLock = 1'b0;
         cyc();
      end
      chk("lock_hdr_count", DW'(hdr_port.size()), DW'(2));
      chk("lock_p1_pops", DW'(pop_p[1]), DW'(4));
      chk("lock_p1_done", DW'(done_n[1]), DW'(1));
      if (hdr_port.size() >= 2) begin
         chk("lock_second_port", DW'(hdr_port[1]), DW'(3));
         chk("lock_second_cyc", DW'(hdr_cyc[1]), DW'(10));
      end

      // Reset in port 2 DATA with 2 beats left; port 2 keeps requesting.
      set_port(2, 20'h2AAAA, 12'd4);
      clr_log();
      req = 4'b0100;
      for (int k = 0; k < 4; k++) cyc();
      rst = 1'b1;
      #1;
      chk("rst_outputs", DW'({gnt, pop, done, GFtsReq, GFwr, busy, GFcbid, GFlen}), '0);
      chk("rst_idata", GFidata, '0);
      chk("rst_no_done", DW'(done_n[2]), DW'(0));
      chk("rst_pops_before", DW'(pop_p[2]), DW'(2));
      @(posedge fclk); #2;
      cyc_n++;
      rst = 1'b0;
      for (int k = 0; k < 9; k++) cyc();
      chk("rst_hdr_count", DW'(hdr_port.size()), DW'(2));
      if (hdr_port.size() >= 2) begin
         chk("rst_regrant_port", DW'(hdr_port[1]), DW'(2));
         chk("rst_regrant_cyc", DW'(hdr_cyc[1]), DW'(6));
         chk("rst_regrant_cbid", DW'(hdr_cbid[1]), DW'(20'h2AAAA));
      end
      chk("rst_total_pops", DW'(pop_p[2]), DW'(6));
      chk("rst_done_after", DW'(done_n[2]), DW'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
